guess_entry_ctrl: RTL and testbench
===================================

// Module: guess_entry_ctrl
// PURPOSE
//  Parametrised successor of read_in: collects a DIGITS-long code from the 4-bit digit switches, one digit per confirm-switch press.
//  Per-digit range check against MAX_VAL; captures the guess budget ("times") in set mode; counts down remaining tries in guess mode.
//  Emits the packed code with a 1-cycle valid pulse to the comparator/LED logic; sits between state_switcher and seven_segment/LED.
// PARAMETERS
//  DIGITS    5   digits per code (1..8)
//  DW        4   bits per digit
//  MAX_VAL   9   largest legal digit value; larger is rejected
//  MAX_TRIES 7   largest legal times value; tries counter width = $clog2(MAX_TRIES+1)
// PORTS
//  clk          in  1          system clock
//  rst_n        in  1          reset: one clock; reset is asynchronous and active-high (legacy net name kept, asserted = 1)
//  mode         in  2          from state_switcher: 0 IDLE, 1 SET (answer entry), 2 GUESS, 3 reserved (treated as IDLE)
//  sw_digit     in  DW         digit switches, raw
//  sw_confirm   in  1          confirm switch (switch5), raw; rising edge = capture
//  sw_times     in  1          switch6: 1 = current press loads times (SET only), 0 = digit
//  sw_clear     in  1          raw, level; discard partial entry
//  code_out     out DIGITS*DW  packed code, digit 0 in LSBs; holds last completed code
//  code_valid   out 1          1-cycle pulse when a full code completes
//  code_is_ans  out 1          qualifies code_valid: 1 = answer (SET), 0 = guess
//  digit_idx    out 3          next digit position 0..DIGITS-1
//  tries_left   out TW         remaining guesses
//  warning      out 1          sticky reject flag
//  locked       out 1          guess budget exhausted
// BEHAVIOUR
//  Reset: all outputs 0, buffer 0, FSM IDLE.
//  Raw inputs pass through a 2-FF synchroniser; confirm edge is detected on the synchronised value.
//  Capture occurs on the 3rd clk edge after sw_confirm rises. Holding the switch high yields exactly one capture.
//  FSM:
//   IDLE    -> COLLECT on mode 1/2.
//   COLLECT -> DONE when digit DIGITS-1 is stored.
//   DONE    -> one cycle: code_out updated, code_valid=1; GUESS: tries_left-=1.
//           -> LOCK if GUESS and tries_left becomes 0, else COLLECT with digit_idx=0.
//   LOCK    -> stays until mode becomes IDLE; then -> IDLE (tries_left kept until next SET times load).
//   Any mode change while COLLECT/DONE: partial entry discarded, digit_idx=0, -> COLLECT (or IDLE if mode 0/3).
//  Capture rules in COLLECT:
//   sw_times=1 & mode SET: value 1..MAX_TRIES loads tries_left, warning cleared; 0 or >MAX_TRIES sets warning, tries unchanged; digit_idx unchanged.
//   sw_times=1 in GUESS: ignored.
//   Digit > MAX_VAL: warning=1, not stored, digit_idx unchanged.
//   Legal digit: stored at digit_idx, digit_idx+1, warning cleared.
//  GUESS completion with tries_left==0 before decrement: no code_valid, warning=1 (guard; unreachable via LOCK).
//  sw_clear (synced level): digit_idx=0, buffer zeroed, warning cleared; wins over a simultaneous confirm edge.
//  Arithmetic: unsigned compares; tries decrement saturates at 0.
//  Reset mid-entry: immediate return to reset values, no code_valid.
// CONFIGURATION
//  GUESS_UNIQUE_DIGITS_EN defined: a legal digit equal to one already stored in the current entry is rejected (warning=1, idx unchanged).
//  Not defined: repeated digits accepted.
// STRUCTURE
//  guess_defs.vh: mode encodings, FSM state localparams, TW derivation macro.
//  Sub-module switch_edge_sync (2-FF sync + rising-edge pulse, width param): one instance for confirm, level outputs for digit/times/clear.
// TESTING
//  Reset high mid-entry (idx=3) -> all outputs 0 next cycle, no code_valid.
//  SET, times=4 then digits 2,3,4,5,6 -> tries_left=4; code_valid once with code_out=0x65432, code_is_ans=1.
//  SET digit 15 -> warning=1, digit_idx unchanged; next digit 2 -> stored, warning=0.
//  GUESS with tries_left=2, two full guesses -> code_valid x2, tries_left 1 then 0, locked=1; further presses ignored.
//  Hold sw_confirm high 20 cycles -> exactly one capture; sw_clear at idx=3 with a simultaneous press -> idx=0, nothing stored.
//  With GUESS_UNIQUE_DIGITS_EN, entry 2,2 -> second rejected, warning=1; without macro, idx=2.

Source files
------------

// File: rtl/guess_entry_ctrl_pkg.sv
// Shared definitions for the guess entry controller: mode encodings,
// FSM state type and helper functions for derived widths.
package guess_entry_ctrl_pkg;

    // Mode codes from state_switcher; code 3 is reserved and behaves as idle
    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_SET   = 2'd1;
    localparam logic [1:0] MODE_GUESS = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_LOCK    = 2'd3
    } state_t;

    // Width of the tries counter so that it can hold 0..max_tries
    function automatic int tries_width(input int max_tries);
        return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
    endfunction

    // Only SET and GUESS open an entry; IDLE and the reserved code do not
    function automatic logic is_entry_mode(input logic [1:0] m);
        return (m == MODE_SET) || (m == MODE_GUESS);
    endfunction

endpackage

// File: rtl/guess_entry_ctrl_if.sv
// Switch-side inputs and code/status outputs of the guess entry controller.
// master = the driver of the switches and mode (board / state_switcher),
// slave  = the entry controller itself.
interface guess_entry_ctrl_if #(
    parameter int DIGITS = 5,
    parameter int DW     = 4,
    parameter int TW     = 3
);
    logic [1:0]           mode;
    logic [DW-1:0]        sw_digit;
    logic                 sw_confirm;
    logic                 sw_times;
    logic                 sw_clear;
    logic [DIGITS*DW-1:0] code_out;
    logic                 code_valid;
    logic                 code_is_ans;
    logic [2:0]           digit_idx;
    logic [TW-1:0]        tries_left;
    logic                 warning;
    logic                 locked;

    modport master (
        output mode, sw_digit, sw_confirm, sw_times, sw_clear,
        input  code_out, code_valid, code_is_ans, digit_idx, tries_left, warning, locked
    );

    modport slave (
        input  mode, sw_digit, sw_confirm, sw_times, sw_clear,
        output code_out, code_valid, code_is_ans, digit_idx, tries_left, warning, locked
    );
endinterface

// File: rtl/guess_entry_ctrl_switch_edge_sync.sv
// Two-flop synchroniser for raw switch inputs with a rising-edge pulse per bit.
// The pulse is high for one cycle, the cycle after the synchronised level rises,
// so a held switch produces exactly one pulse.
module switch_edge_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);
    logic [W-1:0] meta;
    logic [W-1:0] prev;

    // Two-stage synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= '0;
            level <= '0;
            prev  <= '0;
        end else begin
            meta  <= raw;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
endmodule

// File: rtl/guess_entry_ctrl.sv
// Guess entry controller: collects a DIGITS-long code from the digit switches,
// one digit per confirm press, loads the guess budget in SET mode and counts
// down remaining tries in GUESS mode. rst_n is active-high (legacy net name).
// Optional feature macro: GUESS_UNIQUE_DIGITS_EN rejects a digit that repeats
// one already stored in the current entry.
module guess_entry_ctrl
    import guess_entry_ctrl_pkg::*;
#(
    parameter int DIGITS    = 5,
    parameter int DW        = 4,
    parameter int MAX_VAL   = 9,
    parameter int MAX_TRIES = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    guess_entry_ctrl_if.slave bus
);
    localparam int              TW        = tries_width(MAX_TRIES);
    localparam int              SW        = DW + 3;
    localparam logic [DW-1:0]   MAX_DIGIT = DW'(MAX_VAL);
    localparam logic [DW-1:0]   MAX_TIMES = DW'(MAX_TRIES);
    localparam logic [2:0]      LAST_IDX  = 3'(DIGITS - 1);

    // Synchronised switch bundle: bit 0 confirm, then digit, times, clear
    logic [SW-1:0] sw_raw;
    logic [SW-1:0] sw_level;
    logic [SW-1:0] sw_rise;
    logic          confirm_rise;
    logic [DW-1:0] digit_s;
    logic          times_s;
    logic          clear_s;
    logic          sync_unused;

    assign sw_raw = {bus.sw_clear, bus.sw_times, bus.sw_digit, bus.sw_confirm};

    switch_edge_sync #(.W(SW)) u_sync (
        .clk   (clk),
        .rst   (rst_n),
        .raw   (sw_raw),
        .level (sw_level),
        .rise  (sw_rise)
    );

    assign confirm_rise = sw_rise[0];
    assign digit_s      = sw_level[DW:1];
    assign times_s      = sw_level[DW+1];
    assign clear_s      = sw_level[DW+2];
    assign sync_unused  = ^{sw_level[0], sw_rise[SW-1:1]};

    state_t                      state;
    logic [1:0]                  entry_mode;
    logic [DIGITS-1:0][DW-1:0]   buffer;
    logic [DIGITS-1:0][DW-1:0]   next_code;
    logic [2:0]                  idx;
    logic [DIGITS*DW-1:0]        code_out;
    logic                        code_valid;
    logic                        code_is_ans;
    logic [TW-1:0]               tries;
    logic                        warning;
    logic                        locked;
    logic                        dup;

    // Buffer as it would look with the current digit stored at idx
    always_comb begin
        next_code      = buffer;
        next_code[idx] = digit_s;
    end

`ifdef GUESS_UNIQUE_DIGITS_EN
    // Flag a digit that matches any position already filled in this entry
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i < int'(idx)) && (buffer[i] == digit_s)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Entry FSM with all outputs registered
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= ST_IDLE;
            entry_mode  <= MODE_IDLE;
            buffer      <= '0;
            idx         <= '0;
            code_out    <= '0;
            code_valid  <= 1'b0;
            code_is_ans <= 1'b0;
            tries       <= '0;
            warning     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (is_entry_mode(bus.mode)) begin
                        state      <= ST_COLLECT;
                        entry_mode <= bus.mode;
                        buffer     <= '0;
                        idx        <= '0;
                    end
                end

                ST_COLLECT, ST_DONE: begin
                    if (bus.mode != entry_mode) begin
                        buffer <= '0;
                        idx    <= '0;
                        if (is_entry_mode(bus.mode)) begin
                            state      <= ST_COLLECT;
                            entry_mode <= bus.mode;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (state == ST_DONE) begin
                        buffer <= '0;
                        idx    <= '0;
                        if ((entry_mode == MODE_GUESS) && (tries == '0)) begin
                            state  <= ST_LOCK;
                            locked <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end else if (clear_s) begin
                        buffer  <= '0;
                        idx     <= '0;
                        warning <= 1'b0;
                    end else if (confirm_rise) begin
                        if (times_s) begin
                            if (entry_mode == MODE_SET) begin
                                if ((digit_s != '0) && (digit_s <= MAX_TIMES)) begin
                                    tries   <= TW'(digit_s);
                                    warning <= 1'b0;
                                end else begin
                                    warning <= 1'b1;
                                end
                            end
                        end else if ((digit_s > MAX_DIGIT) || dup) begin
                            warning <= 1'b1;
                        end else if (idx != LAST_IDX) begin
                            buffer[idx] <= digit_s;
                            idx         <= idx + 3'd1;
                            warning     <= 1'b0;
                        end else begin
                            buffer[idx] <= digit_s;
                            idx         <= '0;
                            state       <= ST_DONE;
                            if ((entry_mode == MODE_GUESS) && (tries == '0)) begin
                                // No budget left: the guess is swallowed and flagged
                                warning <= 1'b1;
                            end else begin
                                warning     <= 1'b0;
                                code_out    <= next_code;
                                code_valid  <= 1'b1;
                                code_is_ans <= (entry_mode == MODE_SET);
                                if (entry_mode == MODE_GUESS) begin
                                    tries <= (tries == '0) ? '0 : tries - 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_LOCK: begin
                    if (!is_entry_mode(bus.mode)) begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.code_out    = code_out;
    assign bus.code_valid  = code_valid;
    assign bus.code_is_ans = code_is_ans;
    assign bus.digit_idx   = idx;
    assign bus.tries_left  = tries;
    assign bus.warning     = warning;
    assign bus.locked      = locked;
endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Self-checking bench for guess_entry_ctrl: expected codes are queued when the
// final digit of an entry is driven and compared whenever code_valid pulses.
// Build with +define+GUESS_UNIQUE_DIGITS_EN to match the unique-digit variant.
module tb_guess_entry_ctrl;
    import guess_entry_ctrl_pkg::*;

    localparam int DIGITS = 5;
    localparam int DW     = 4;
    localparam int TW     = tries_width(7);
    localparam int CW     = DIGITS * DW;

    typedef struct packed {
        logic [CW-1:0] code;
        logic          ans;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   valid_seen;
    int   pushed;
    exp_t exp_q[$];
    exp_t exp_item;

    guess_entry_ctrl_if #(.DIGITS(DIGITS), .DW(DW), .TW(TW)) bus ();

    guess_entry_ctrl #(
        .DIGITS    (DIGITS),
        .DW        (DW),
        .MAX_VAL   (9),
        .MAX_TRIES (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One confirm press: value and times switch held with confirm for hold cycles
    task automatic apply_stimulus(input logic [3:0] value, input logic times, input int hold);
        @(negedge clk);
        bus.sw_digit   = value;
        bus.sw_times   = times;
        bus.sw_confirm = 1'b1;
        repeat (hold) @(negedge clk);
        bus.sw_confirm = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic enter_code(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3, input logic [3:0] d4, input logic expect_valid,
                              input logic ans);
        apply_stimulus(d0, 1'b0, 4);
        apply_stimulus(d1, 1'b0, 4);
        apply_stimulus(d2, 1'b0, 4);
        apply_stimulus(d3, 1'b0, 4);
        if (expect_valid) begin
            exp_q.push_back('{code: {d4, d3, d2, d1, d0}, ans: ans});
            pushed++;
        end
        apply_stimulus(d4, 1'b0, 4);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_code_out"},    32'(bus.code_out),    32'd0);
        check_output({tag, "_code_valid"},  32'(bus.code_valid),  32'd0);
        check_output({tag, "_code_is_ans"}, 32'(bus.code_is_ans), 32'd0);
        check_output({tag, "_digit_idx"},   32'(bus.digit_idx),   32'd0);
        check_output({tag, "_tries_left"},  32'(bus.tries_left),  32'd0);
        check_output({tag, "_warning"},     32'(bus.warning),     32'd0);
        check_output({tag, "_locked"},      32'(bus.locked),      32'd0);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        bus.mode = m;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard side: every code_valid pulse must match the oldest queued entry
    always @(negedge clk) begin
        if (!rst_n && bus.code_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check_output("sb_code_out",    32'(bus.code_out),    32'(exp_item.code));
                check_output("sb_code_is_ans", 32'(bus.code_is_ans), 32'(exp_item.ans));
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        valid_seen     = 0;
        pushed         = 0;
        rst_n          = 1'b1;
        bus.mode       = MODE_IDLE;
        bus.sw_digit   = '0;
        bus.sw_confirm = 1'b0;
        bus.sw_times   = 1'b0;
        bus.sw_clear   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b0;

        $display("[TB] reset in the middle of an entry");
        set_mode(MODE_SET);
        apply_stimulus(4'd4, 1'b1, 4);
        apply_stimulus(4'd2, 1'b0, 4);
        apply_stimulus(4'd3, 1'b0, 4);
        apply_stimulus(4'd4, 1'b0, 4);
        check_output("mid_idx", 32'(bus.digit_idx), 32'd3);
        check_output("mid_tries", 32'(bus.tries_left), 32'd4);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] answer entry with times load");
        apply_stimulus(4'd4, 1'b1, 4);
        check_output("times4_tries", 32'(bus.tries_left), 32'd4);
        check_output("times4_idx", 32'(bus.digit_idx), 32'd0);
        enter_code(4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1, 1'b1);
        check_output("ans_idx", 32'(bus.digit_idx), 32'd0);
        check_output("ans_tries", 32'(bus.tries_left), 32'd4);
        check_output("ans_code_hold", 32'(bus.code_out), 32'h65432);

        $display("[TB] range checks on digits and times");
        apply_stimulus(4'd15, 1'b0, 4);
        check_output("d15_warning", 32'(bus.warning), 32'd1);
        check_output("d15_idx", 32'(bus.digit_idx), 32'd0);
        apply_stimulus(4'd2, 1'b0, 4);
        check_output("d2_warning", 32'(bus.warning), 32'd0);
        check_output("d2_idx", 32'(bus.digit_idx), 32'd1);
        apply_stimulus(4'd9, 1'b0, 4);
        check_output("d9_idx", 32'(bus.digit_idx), 32'd2);
        apply_stimulus(4'd10, 1'b0, 4);
        check_output("d10_warning", 32'(bus.warning), 32'd1);
        check_output("d10_idx", 32'(bus.digit_idx), 32'd2);
        apply_stimulus(4'd0, 1'b1, 4);
        check_output("t0_warning", 32'(bus.warning), 32'd1);
        check_output("t0_tries", 32'(bus.tries_left), 32'd4);
        apply_stimulus(4'd8, 1'b1, 4);
        check_output("t8_tries", 32'(bus.tries_left), 32'd4);
        apply_stimulus(4'd7, 1'b1, 4);
        check_output("t7_tries", 32'(bus.tries_left), 32'd7);
        check_output("t7_warning", 32'(bus.warning), 32'd0);
        apply_stimulus(4'd2, 1'b1, 4);
        check_output("t2_tries", 32'(bus.tries_left), 32'd2);
        check_output("t2_idx", 32'(bus.digit_idx), 32'd2);

        $display("[TB] clear beats a simultaneous press");
        apply_stimulus(4'd4, 1'b0, 4);
        check_output("pre_clear_idx", 32'(bus.digit_idx), 32'd3);
        apply_stimulus(4'd15, 1'b0, 4);
        check_output("pre_clear_warning", 32'(bus.warning), 32'd1);
        @(negedge clk);
        bus.sw_digit   = 4'd7;
        bus.sw_times   = 1'b0;
        bus.sw_clear   = 1'b1;
        bus.sw_confirm = 1'b1;
        repeat (4) @(negedge clk);
        bus.sw_confirm = 1'b0;
        repeat (2) @(negedge clk);
        bus.sw_clear = 1'b0;
        repeat (4) @(negedge clk);
        check_output("clear_idx", 32'(bus.digit_idx), 32'd0);
        check_output("clear_warning", 32'(bus.warning), 32'd0);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b1, 1'b1);

        $display("[TB] held confirm gives a single capture");
        apply_stimulus(4'd7, 1'b0, 20);
        check_output("hold_idx", 32'(bus.digit_idx), 32'd1);
        set_mode(MODE_IDLE);
        check_output("idle_discard_idx", 32'(bus.digit_idx), 32'd0);

        $display("[TB] repeated digit handling");
        set_mode(MODE_SET);
        apply_stimulus(4'd2, 1'b0, 4);
        apply_stimulus(4'd2, 1'b0, 4);
`ifdef GUESS_UNIQUE_DIGITS_EN
        check_output("repeat_idx", 32'(bus.digit_idx), 32'd1);
        check_output("repeat_warning", 32'(bus.warning), 32'd1);
`else
        check_output("repeat_idx", 32'(bus.digit_idx), 32'd2);
        check_output("repeat_warning", 32'(bus.warning), 32'd0);
`endif

        $display("[TB] guesses until the budget runs out");
        set_mode(MODE_GUESS);
        check_output("guess_discard_idx", 32'(bus.digit_idx), 32'd0);
        apply_stimulus(4'd5, 1'b1, 4);
        check_output("guess_times_ignored", 32'(bus.tries_left), 32'd2);
        check_output("guess_times_idx", 32'(bus.digit_idx), 32'd0);
        enter_code(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        check_output("g1_tries", 32'(bus.tries_left), 32'd1);
        check_output("g1_locked", 32'(bus.locked), 32'd0);
        enter_code(4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 1'b1, 1'b0);
        check_output("g2_tries", 32'(bus.tries_left), 32'd0);
        check_output("g2_locked", 32'(bus.locked), 32'd1);
        apply_stimulus(4'd3, 1'b0, 4);
        check_output("lock_idx", 32'(bus.digit_idx), 32'd0);
        check_output("lock_code_hold", 32'(bus.code_out), 32'h98765);
        set_mode(MODE_IDLE);
        check_output("unlock_locked", 32'(bus.locked), 32'd0);
        check_output("unlock_tries", 32'(bus.tries_left), 32'd0);

        $display("[TB] guess with an empty budget");
        set_mode(MODE_GUESS);
        enter_code(4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 1'b0, 1'b0);
        check_output("empty_warning", 32'(bus.warning), 32'd1);
        check_output("empty_tries", 32'(bus.tries_left), 32'd0);
        check_output("empty_code_hold", 32'(bus.code_out), 32'h98765);

        repeat (4) @(negedge clk);
        check_output("sb_empty", 32'(exp_q.size()), 32'd0);
        check_output("valid_count", 32'(valid_seen), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
